// File: rtl/kb_event_queue_if.sv
// CPU-side and scan-code-side signal bundle for the keyboard event queue.
// The master is the receiver/CPU bus side; the slave is the queue itself.
interface kb_event_queue_if;
  logic [7:0] SC_DATA;
  logic       SC_VALID;
  logic       CS_N;
  logic       RD_N;
  logic       A0;
  logic [7:0] DOUT;
  logic       DOE;
  logic       IRQ_N;

  modport master (
    output SC_DATA, SC_VALID, CS_N, RD_N, A0,
    input  DOUT, DOE, IRQ_N
  );

  modport slave (
    input  SC_DATA, SC_VALID, CS_N, RD_N, A0,
    output DOUT, DOE, IRQ_N
  );
endinterface

// File: rtl/kb_event_queue.sv
// Folds PS/2 set-2 E0/F0 prefixes into {brk, ext, code} events and queues them
// behind a two-register (DATA/STATUS) CPU read port.
module kb_event_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            CLK,
  input  logic            RST,
  kb_event_queue_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } pfx_state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  pfx_state_t  state_reg, state_next;
  logic        push_req;
  logic        err_set;
  logic        ext_bit, brk_bit;
  logic [9:0]  entry;

  logic [9:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] count_reg, count_next;
  logic        ovf_reg, err_reg;
  logic        rd_q_reg, a0_q_reg;
  logic        irq_n_reg;

  logic        empty, full;
  logic        rd_act, rd_end;
  logic        pop, push_ok, ovf_set, stat_clr;
  logic [9:0]  head;
  logic [7:0]  rd_data;

  // Prefix tracker: only SC_VALID cycles move it.
  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    err_set    = 1'b0;
    if (bus.SC_VALID) begin
      case (bus.SC_DATA)
        8'hE0: begin
          if (state_reg == ST_IDLE)     state_next = ST_E0;
          else if (state_reg == ST_F0)  state_next = ST_E0F0;
        end
        8'hF0: begin
          if (state_reg == ST_IDLE)     state_next = ST_F0;
          else if (state_reg == ST_E0)  state_next = ST_E0F0;
        end
        8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
        end
        8'h00, 8'hFF: begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
        default: begin
          push_req   = 1'b1;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign ext_bit = (state_reg == ST_E0) || (state_reg == ST_E0F0);
  assign brk_bit = (state_reg == ST_F0) || (state_reg == ST_E0F0);
  assign entry   = {brk_bit, ext_bit, bus.SC_DATA};

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_COUNT);
  assign rd_act   = ~bus.CS_N & ~bus.RD_N;
  assign rd_end   = rd_q_reg & ~rd_act;
  assign pop      = rd_end & ~a0_q_reg & ~empty;
  assign stat_clr = rd_end & a0_q_reg;
  // A same-cycle pop frees a slot before the push is judged.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;

  assign count_next = count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  assign head       = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      err_reg    <= 1'b0;
      rd_q_reg   <= 1'b0;
      a0_q_reg   <= 1'b0;
      irq_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      rd_q_reg  <= rd_act;
      if (rd_act) a0_q_reg <= bus.A0;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      ovf_reg   <= ovf_set | (ovf_reg & ~stat_clr);
      err_reg   <= err_set | (err_reg & ~stat_clr);
      irq_n_reg <= (count_next == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr_reg] <= entry;
  end

  // Read data is purely combinational so it holds for the whole bus access.
  always_comb begin
    rd_data = 8'h00;
    if (bus.A0) begin
      rd_data = {~empty, full, ovf_reg, err_reg, 2'b00,
                 ~empty & head[8], ~empty & head[9]};
    end else if (!empty) begin
      rd_data = head[7:0];
    end
  end

  assign bus.DOUT  = rd_data;
  assign bus.DOE   = rd_act;
  assign bus.IRQ_N = irq_n_reg;

endmodule

// File: tb/tb_kb_event_queue.sv
// Scoreboarded bench: stimulus queues expected read data from a queue-based
// keyboard model; a negedge monitor checks each bus read and IRQ_N.
module tb_kb_event_queue;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  kb_event_queue_if bus();

  kb_event_queue #(.DEPTH(DEPTH), .AW(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;

  int   m_fifo[$];
  bit   m_ext, m_brk, m_ovf, m_err;
  bit   chk_en = 1'b0;
  logic doe_prev = 1'b0;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model
  function automatic logic [7:0] m_data();
    int h;
    if (m_fifo.size() == 0) return 8'h00;
    h = m_fifo[0];
    return h[7:0];
  endfunction

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    int h;
    s = 8'h00;
    s[7] = (m_fifo.size() != 0);
    s[6] = (m_fifo.size() == DEPTH);
    s[5] = m_ovf;
    s[4] = m_err;
    if (m_fifo.size() != 0) begin
      h = m_fifo[0];
      s[1] = h[8];
      s[0] = h[9];
    end
    return s;
  endfunction

  task automatic m_sc(logic [7:0] b);
    case (b)
      8'hE0: m_ext = 1'b1;
      8'hF0: m_brk = 1'b1;
      8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
      end
      8'h00, 8'hFF: begin
        m_err = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
      default: begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(int'({m_brk, m_ext, b}));
        else m_ovf = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    endcase
  endtask

  task automatic m_read_end(bit a0);
    if (!a0) begin
      if (m_fifo.size() != 0) void'(m_fifo.pop_front());
    end else begin
      m_ovf = 1'b0;
      m_err = 1'b0;
    end
  endtask

  task automatic m_clear();
    m_fifo.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  // Stimulus
  task automatic sc_send(logic [7:0] b);
    $display("[TB] sc %02h", b);
    bus.SC_DATA  = b;
    bus.SC_VALID = 1'b1;
    tick();
    bus.SC_VALID = 1'b0;
    m_sc(b);
  endtask

  task automatic start_read(bit a0, string name);
    exp_t e;
    e.name = name;
    e.val  = a0 ? m_status() : m_data();
    exp_q.push_back(e);
    bus.A0   = a0;
    bus.CS_N = 1'b0;
    bus.RD_N = 1'b0;
  endtask

  task automatic cpu_read(bit a0, string name);
    start_read(a0, name);
    tick();
    tick();
    bus.CS_N = 1'b1;
    bus.RD_N = 1'b1;
    tick();
    m_read_end(a0);
  endtask

  // DATA read whose side-effect cycle coincides with a scan-code strobe.
  task automatic cpu_read_with_sc(logic [7:0] b, string name);
    start_read(1'b0, name);
    tick();
    tick();
    bus.CS_N     = 1'b1;
    bus.RD_N     = 1'b1;
    bus.SC_DATA  = b;
    bus.SC_VALID = 1'b1;
    $display("[TB] sc %02h with read end", b);
    tick();
    bus.SC_VALID = 1'b0;
    m_read_end(1'b0);
    m_sc(b);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    m_clear();
    chk_en = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 19);
    if (r < 2)  return 8'hE0;
    if (r < 4)  return 8'hF0;
    if (r == 4) begin
      case ($urandom_range(0, 3))
        0: return 8'hFA;
        1: return 8'hAA;
        2: return 8'hEE;
        default: return 8'hFE;
      endcase
    end
    if (r == 5) return ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
    return 8'($urandom_range(1, 127));
  endfunction

  // Monitor: compares each read at its first DOE cycle, and IRQ_N every cycle.
  always @(negedge CLK) begin
    if (bus.DOE === 1'b1 && doe_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got dout %02h with nothing expected", bus.DOUT);
      end else begin
        cur = exp_q.pop_front();
        $display("[TB] rd %s a0=%0b dout=%02h exp=%02h", cur.name, bus.A0, bus.DOUT, cur.val);
        check(cur.name, bus.DOUT, cur.val);
      end
    end
    if (chk_en) check("irq_n", {7'b0, bus.IRQ_N}, {7'b0, m_fifo.size() == 0});
    doe_prev = bus.DOE;
  end

  initial begin
    int op;
    bus.SC_DATA  = 8'h00;
    bus.SC_VALID = 1'b0;
    bus.CS_N     = 1'b1;
    bus.RD_N     = 1'b1;
    bus.A0       = 1'b0;
    m_clear();

    do_reset();
    check("reset_doe", {7'b0, bus.DOE}, 8'h00);

    // Single make code
    sc_send(8'h1C);
    cpu_read(1'b1, "st_one");
    cpu_read(1'b0, "data_1c");
    cpu_read(1'b1, "st_empty");

    // Extended break and plain break
    sc_send(8'hE0); sc_send(8'hF0); sc_send(8'h75);
    cpu_read(1'b1, "st_extbrk");
    cpu_read(1'b0, "data_75");
    sc_send(8'hF0); sc_send(8'h12);
    cpu_read(1'b1, "st_brk");
    cpu_read(1'b0, "data_12");

    // Overflow: DEPTH+1 pushes, then another drop after OVF was cleared
    for (int i = 0; i <= DEPTH; i++) sc_send(8'(8'h10 + i));
    cpu_read(1'b1, "st_full_ovf");
    sc_send(8'h19);
    for (int i = 0; i < DEPTH; i++) cpu_read(1'b0, "data_ovf_seq");
    cpu_read(1'b1, "st_ovf_only");
    cpu_read(1'b1, "st_ovf_clr");

    // Full FIFO: pop and push in the same cycle
    for (int i = 0; i < DEPTH; i++) sc_send(8'(8'h30 + i));
    cpu_read_with_sc(8'h44, "data_pop_push");
    cpu_read(1'b1, "st_full_no_ovf");
    for (int i = 0; i < DEPTH; i++) cpu_read(1'b0, "data_drain");

    // Discarded bytes, error byte, prefix aborted by reset
    sc_send(8'hFA); sc_send(8'hAA);
    cpu_read(1'b1, "st_discard");
    sc_send(8'h00);
    cpu_read(1'b1, "st_err");
    cpu_read(1'b1, "st_err_clr");
    sc_send(8'hE0);
    do_reset();
    sc_send(8'h1C);
    cpu_read(1'b1, "st_after_rst");
    cpu_read(1'b0, "data_after_rst");

    // Empty read and non-selected read strobe
    cpu_read(1'b0, "data_empty");
    check("doe_after_read", {7'b0, bus.DOE}, 8'h00);
    cpu_read(1'b1, "st_empty2");
    bus.CS_N = 1'b1;
    bus.RD_N = 1'b0;
    #1;
    check("doe_not_selected", {7'b0, bus.DOE}, 8'h00);
    tick();
    bus.RD_N = 1'b1;

    // Reset in the middle of a DATA read: no pop, queue flushed
    sc_send(8'h21); sc_send(8'h22);
    start_read(1'b0, "data_before_rst");
    tick();
    chk_en = 1'b0;
    RST = 1'b0;
    tick();
    bus.CS_N = 1'b1;
    bus.RD_N = 1'b1;
    tick();
    RST = 1'b1;
    m_clear();
    chk_en = 1'b1;
    cpu_read(1'b1, "st_rst_mid_read");

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 19);
      if (op < 10)      sc_send(rand_byte());
      else if (op < 14) cpu_read(1'b0, "rnd_data");
      else if (op < 17) cpu_read(1'b1, "rnd_status");
      else              cpu_read_with_sc(8'($urandom_range(1, 127)), "rnd_data_push");
    end

    tick();
    tick();
    check("reads_all_seen", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
